// File: rtl/pc_counter_responder.sv
// pc_counter_responder: responder node of the performance-counter daisy chain.
// It counts FIRE / STALL / IDLE handshake events on NUM_PORTS monitored
// valid/ready pairs in 16-bit saturating counters. It answers chain read requests
// addressed to MODULE_ID. Every other chain word is forwarded after one register stage.
// Optional feature macro: PC_CLEAR_ON_READ_EN. When it is defined, an in-range read
// clears the counter it reads.
module pc_counter_responder #(
    parameter logic [15:0] MODULE_ID = 16'd1,
    parameter int          NUM_PORTS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] mon_valid,
    input  logic [NUM_PORTS-1:0] mon_ready,
    input  logic                 io_pcIn_valid,
    input  logic                 io_pcIn_bits_request,
    input  logic [15:0]          io_pcIn_bits_moduleId,
    input  logic [7:0]           io_pcIn_bits_portId,
    input  logic [15:0]          io_pcIn_bits_pcValue,
    input  logic [3:0]           io_pcIn_bits_pcType,
    output logic                 io_pcOut_valid,
    output logic                 io_pcOut_bits_request,
    output logic [15:0]          io_pcOut_bits_moduleId,
    output logic [7:0]           io_pcOut_bits_portId,
    output logic [15:0]          io_pcOut_bits_pcValue,
    output logic [3:0]           io_pcOut_bits_pcType
);

    localparam int NUM_TYPES = 3;

    // A request on the chain that targets this node.
    logic hit;
    assign hit = io_pcIn_valid && io_pcIn_bits_request &&
                 (io_pcIn_bits_moduleId == MODULE_ID);

    // All counters flattened to one vector so the read mux can index them.
    // The slot for port p and type t is at (p*NUM_TYPES + t)*16.
    logic [NUM_PORTS*NUM_TYPES*16-1:0] cnt_flat;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            // Per-port events. Bit 0 is FIRE, bit 1 is STALL and bit 2 is IDLE.
            logic [NUM_TYPES-1:0] ev;
            assign ev = {mon_ready[gi] & ~mon_valid[gi],
                         mon_valid[gi] & ~mon_ready[gi],
                         mon_valid[gi] &  mon_ready[gi]};

            for (gj = 0; gj < NUM_TYPES; gj++) begin : g_type
                logic [15:0] cnt_q;
                logic [15:0] cnt_d;
`ifdef PC_CLEAR_ON_READ_EN
                logic rd_sel;
                assign rd_sel = hit &&
                                (io_pcIn_bits_portId == 8'(gi)) &&
                                (io_pcIn_bits_pcType == 4'(gj));
`endif

                // Saturating increment. An in-range read can clear the counter to this cycle's event.
                always_comb begin
                    cnt_d = cnt_q;
                    if (ev[gj] && (cnt_q != 16'hFFFF)) begin
                        cnt_d = cnt_q + 16'd1;
                    end
`ifdef PC_CLEAR_ON_READ_EN
                    if (rd_sel) begin
                        cnt_d = {15'd0, ev[gj]};
                    end
`endif
                end

                // Counter storage, cleared by reset.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_q <= 16'd0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign cnt_flat[(gi*NUM_TYPES+gj)*16 +: 16] = cnt_q;
            end
        end
    endgenerate

    // Read mux. Out-of-range portId or pcType matches nothing and returns zero.
    logic [15:0] rd_value;
    always_comb begin
        rd_value = 16'h0000;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                if ((io_pcIn_bits_portId == p[7:0]) && (io_pcIn_bits_pcType == t[3:0])) begin
                    rd_value = cnt_flat[(p*NUM_TYPES+t)*16 +: 16];
                end
            end
        end
    end

    // Chain stage registers.
    logic        valid_q,   valid_d;
    logic        request_q, request_d;
    logic [15:0] module_q,  module_d;
    logic [7:0]  port_q,    port_d;
    logic [15:0] value_q,   value_d;
    logic [3:0]  type_q,    type_d;

    // Next chain word. A hit becomes a response, other valid words pass through, and idle cycles hold the bits.
    always_comb begin
        valid_d   = io_pcIn_valid;
        request_d = request_q;
        module_d  = module_q;
        port_d    = port_q;
        value_d   = value_q;
        type_d    = type_q;
        if (io_pcIn_valid) begin
            module_d = io_pcIn_bits_moduleId;
            port_d   = io_pcIn_bits_portId;
            type_d   = io_pcIn_bits_pcType;
            if (hit) begin
                request_d = 1'b0;
                value_d   = rd_value;
            end else begin
                request_d = io_pcIn_bits_request;
                value_d   = io_pcIn_bits_pcValue;
            end
        end
    end

    // Single pipeline register for the chain word. Reset drops any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            request_q <= 1'b0;
            module_q  <= 16'd0;
            port_q    <= 8'd0;
            value_q   <= 16'd0;
            type_q    <= 4'd0;
        end else begin
            valid_q   <= valid_d;
            request_q <= request_d;
            module_q  <= module_d;
            port_q    <= port_d;
            value_q   <= value_d;
            type_q    <= type_d;
        end
    end

    assign io_pcOut_valid         = valid_q;
    assign io_pcOut_bits_request  = request_q;
    assign io_pcOut_bits_moduleId = module_q;
    assign io_pcOut_bits_portId   = port_q;
    assign io_pcOut_bits_pcValue  = value_q;
    assign io_pcOut_bits_pcType   = type_q;

endmodule

// File: tb/tb_pc_counter_responder.sv
// Directed testbench for pc_counter_responder with the default parameters (MODULE_ID=1, NUM_PORTS=4).
module tb_pc_counter_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  mon_valid;
    logic [3:0]  mon_ready;
    logic        in_valid;
    logic        in_request;
    logic [15:0] in_module;
    logic [7:0]  in_port;
    logic [15:0] in_value;
    logic [3:0]  in_type;
    logic        out_valid;
    logic        out_request;
    logic [15:0] out_module;
    logic [7:0]  out_port;
    logic [15:0] out_value;
    logic [3:0]  out_type;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_counter_responder #(
        .MODULE_ID(16'd1),
        .NUM_PORTS(4)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .mon_valid             (mon_valid),
        .mon_ready             (mon_ready),
        .io_pcIn_valid         (in_valid),
        .io_pcIn_bits_request  (in_request),
        .io_pcIn_bits_moduleId (in_module),
        .io_pcIn_bits_portId   (in_port),
        .io_pcIn_bits_pcValue  (in_value),
        .io_pcIn_bits_pcType   (in_type),
        .io_pcOut_valid        (out_valid),
        .io_pcOut_bits_request (out_request),
        .io_pcOut_bits_moduleId(out_module),
        .io_pcOut_bits_portId  (out_port),
        .io_pcOut_bits_pcValue (out_value),
        .io_pcOut_bits_pcType  (out_type)
    );

    // Output word packed as {valid, request, moduleId, portId, pcValue, pcType}.
    function automatic logic [45:0] out_word();
        return {out_valid, out_request, out_module, out_port, out_value, out_type};
    endfunction

    function automatic logic [45:0] mk(input logic req, input logic [15:0] m,
                                       input logic [7:0] p, input logic [15:0] v,
                                       input logic [3:0] t);
        return {1'b1, req, m, p, v, t};
    endfunction

    task automatic check(input string name, input logic [45:0] obs, input logic [45:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", name, obs, exp);
    endtask

    // Drives one chain word just after a falling edge. Samples the registered result at the next falling edge.
    task automatic xfer(input logic req, input logic [15:0] m, input logic [7:0] p,
                        input logic [15:0] v, input logic [3:0] t, output logic [45:0] got);
        in_valid   = 1'b1;
        in_request = req;
        in_module  = m;
        in_port    = p;
        in_value   = v;
        in_type    = t;
        @(posedge clk);
        @(negedge clk);
        got      = out_word();
        in_valid = 1'b0;
    endtask

    logic [45:0] got;

    initial begin
        reset_n    = 1'b0;
        mon_valid  = 4'b0;
        mon_ready  = 4'b0;
        in_valid   = 1'b1;
        in_request = 1'b0;
        in_module  = 16'h0055;
        in_port    = 8'h3;
        in_value   = 16'hBEEF;
        in_type    = 4'h2;

        // Test 1: the reset holds the outputs at zero even though a word is presented.
        repeat (3) @(negedge clk);
        check("reset_hold", out_word(), 46'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        check("post_reset", out_word(), 46'd0);
        xfer(1'b1, 16'd1, 8'd0, 16'h0000, 4'd0, got);
        check("rd_p0_fire", got, mk(1'b0, 16'd1, 8'd0, 16'd0, 4'd0));

        // Test 2: port 1 fires for 10 cycles.
        mon_valid[1] = 1'b1;
        mon_ready[1] = 1'b1;
        repeat (10) @(negedge clk);
        mon_valid[1] = 1'b0;
        mon_ready[1] = 1'b0;
        xfer(1'b1, 16'd1, 8'd1, 16'h0000, 4'd0, got);
        check("rd_p1_fire", got, mk(1'b0, 16'd1, 8'd1, 16'd10, 4'd0));
        xfer(1'b1, 16'd1, 8'd1, 16'h0000, 4'd1, got);
        check("rd_p1_stall", got, mk(1'b0, 16'd1, 8'd1, 16'd0, 4'd1));

        // Test 3: words not addressed to this node pass through unchanged.
        xfer(1'b1, 16'd7, 8'd2, 16'h1234, 4'd1, got);
        check("pass_req", got, mk(1'b1, 16'd7, 8'd2, 16'h1234, 4'd1));
        xfer(1'b0, 16'd1, 8'd3, 16'hABCD, 4'd2, got);
        check("pass_resp", got, mk(1'b0, 16'd1, 8'd3, 16'hABCD, 4'd2));

        // Idle cycle: the valid bit drops and the bits hold the last word.
        @(negedge clk);
        check("idle_hold", out_word(), {1'b0, 1'b0, 16'd1, 8'd3, 16'hABCD, 4'd2});

        // Test 4: out-of-range reads return zero, and the input pcValue is ignored.
        xfer(1'b1, 16'd1, 8'd4, 16'h5555, 4'd0, got);
        check("oor_port", got, mk(1'b0, 16'd1, 8'd4, 16'd0, 4'd0));
        xfer(1'b1, 16'd1, 8'd0, 16'h7777, 4'd5, got);
        check("oor_type5", got, mk(1'b0, 16'd1, 8'd0, 16'd0, 4'd5));
        xfer(1'b1, 16'd1, 8'd1, 16'h0000, 4'd3, got);
        check("oor_type3", got, mk(1'b0, 16'd1, 8'd1, 16'd0, 4'd3));

        // An asynchronous reset clears the outputs at once and also clears the counters.
        mon_valid[1] = 1'b1;
        mon_ready[1] = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset", out_word(), 46'd0);
        mon_valid[1] = 1'b0;
        mon_ready[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        xfer(1'b1, 16'd1, 8'd1, 16'h0000, 4'd0, got);
        check("rd_p1_cleared", got, mk(1'b0, 16'd1, 8'd1, 16'd0, 4'd0));

        // Test 5: port 3 stalls long enough for its counter to saturate.
        mon_valid[3] = 1'b1;
        repeat (70000) @(negedge clk);
        xfer(1'b1, 16'd1, 8'd3, 16'h0000, 4'd1, got);
        check("sat_first", got, mk(1'b0, 16'd1, 8'd3, 16'hFFFF, 4'd1));
        repeat (3) @(negedge clk);
        xfer(1'b1, 16'd1, 8'd3, 16'h0000, 4'd1, got);
`ifdef PC_CLEAR_ON_READ_EN
        check("sat_again", got, mk(1'b0, 16'd1, 8'd3, 16'd4, 4'd1));
`else
        check("sat_again", got, mk(1'b0, 16'd1, 8'd3, 16'hFFFF, 4'd1));
`endif
        mon_valid[3] = 1'b0;

        // Test 6: back-to-back reads of the port 0 FIRE counter while port 0 fires.
        mon_valid[0] = 1'b1;
        mon_ready[0] = 1'b1;
        repeat (5) @(negedge clk);
        xfer(1'b1, 16'd1, 8'd0, 16'h0000, 4'd0, got);
        check("b2b_first", got, mk(1'b0, 16'd1, 8'd0, 16'd5, 4'd0));
        xfer(1'b1, 16'd1, 8'd0, 16'h0000, 4'd0, got);
`ifdef PC_CLEAR_ON_READ_EN
        check("b2b_second", got, mk(1'b0, 16'd1, 8'd0, 16'd1, 4'd0));
`else
        check("b2b_second", got, mk(1'b0, 16'd1, 8'd0, 16'd6, 4'd0));
`endif
        mon_valid[0] = 1'b0;
        mon_ready[0] = 1'b0;

        // The idle count on port 2 reads back through type 2.
        mon_ready[2] = 1'b1;
        repeat (2) @(negedge clk);
        mon_ready[2] = 1'b0;
        xfer(1'b1, 16'd1, 8'd2, 16'h0000, 4'd2, got);
        check("rd_p2_idle", got, mk(1'b0, 16'd1, 8'd2, 16'd2, 4'd2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
